// File: rtl/trace_capture_fifo.sv
// Trace capture FIFO: records register write-back and store events from a CPU
// pipeline into a show-ahead queue, with a sticky overflow flag and drop counter.
module trace_capture_fifo #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             reg_we,
  input  logic [4:0]       reg_addr,
  input  logic [31:0]      reg_data,
  input  logic             mem_we,
  input  logic [31:0]      mem_addr,
  input  logic [31:0]      mem_data,
  input  logic             out_ready,
  input  logic             clr_ovf,
  output logic             out_valid,
  output logic             out_kind,
  output logic [31:0]      out_addr,
  output logic [31:0]      out_data,
  output logic [CNT_W-1:0] count,
  output logic             overflow,
  output logic [15:0]      drop_cnt
);

  localparam int PTR_W = CNT_W - 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic             kind_q [DEPTH];
  logic [31:0]      addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];

  logic [PTR_W-1:0] wp_q, wp_d;
  logic [PTR_W-1:0] rp_q, rp_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [15:0]      drop_q, drop_d;

  logic             regEvt, memEvt;
  logic             admit, drop, pop;
  logic             pushReg, pushMem;
  logic [CNT_W-1:0] evtCnt, space, pushCnt;
  logic [PTR_W-1:0] memSlot;

  // Admission is all-or-nothing and judged against occupancy before any same-cycle pop.
  always_comb begin
    regEvt  = en & reg_we & (reg_addr != 5'd0);
    memEvt  = en & mem_we;
    evtCnt  = CNT_W'(regEvt) + CNT_W'(memEvt);
    space   = DEPTH_C - count_q;
    admit   = (evtCnt <= space);
    drop    = (evtCnt != '0) && !admit;
    pushReg = regEvt & admit;
    pushMem = memEvt & admit;
    pushCnt = admit ? evtCnt : '0;
    pop     = (count_q != '0) && out_ready;
    memSlot = wp_q + PTR_W'(pushReg);
  end

  always_comb begin
    wp_d       = wp_q + PTR_W'(pushCnt);
    rp_d       = rp_q + PTR_W'(pop);
    count_d    = count_q + pushCnt - CNT_W'(pop);
    overflow_d = overflow_q;
    drop_d     = drop_q;
    // A clear wins over a drop in the same cycle, so that drop goes unrecorded.
    if (clr_ovf) begin
      overflow_d = 1'b0;
      drop_d     = '0;
    end else if (drop) begin
      overflow_d = 1'b1;
      if (drop_q != 16'hFFFF) begin
        drop_d = drop_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q       <= '0;
      rp_q       <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end

  // The register event is the older instruction, so it takes slot wp and the store wp+1.
  always_ff @(posedge clk) begin
    if (!rst && pushReg) begin
      kind_q[wp_q] <= 1'b0;
      addr_q[wp_q] <= {27'd0, reg_addr};
      data_q[wp_q] <= reg_data;
    end
    if (!rst && pushMem) begin
      kind_q[memSlot] <= 1'b1;
      addr_q[memSlot] <= mem_addr;
      data_q[memSlot] <= mem_data;
    end
  end

  assign out_valid = (count_q != '0);
  assign out_kind  = kind_q[rp_q];
  assign out_addr  = addr_q[rp_q];
  assign out_data  = data_q[rp_q];
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_trace_capture_fifo.sv
// Self-checking bench for trace_capture_fifo: a queue scoreboard models the
// FIFO contents, admission rule, and overflow/drop bookkeeping.
module tb_trace_capture_fifo;

  localparam int DEPTH = 16;
  localparam int CNT_W = 5;

  typedef struct {
    logic        kind;
    logic [31:0] addr;
    logic [31:0] data;
  } ent_t;

  logic             clk;
  logic             rst;
  logic             en;
  logic             reg_we;
  logic [4:0]       reg_addr;
  logic [31:0]      reg_data;
  logic             mem_we;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_data;
  logic             out_ready;
  logic             clr_ovf;
  logic             out_valid;
  logic             out_kind;
  logic [31:0]      out_addr;
  logic [31:0]      out_data;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic [15:0]      drop_cnt;

  ent_t sbq[$];
  int   nCompared = 0;
  int   nMismatch = 0;
  int   expDrops  = 0;

  trace_capture_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .en(en),
    .reg_we(reg_we), .reg_addr(reg_addr), .reg_data(reg_data),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
    .out_ready(out_ready), .clr_ovf(clr_ovf),
    .out_valid(out_valid), .out_kind(out_kind), .out_addr(out_addr), .out_data(out_data),
    .count(count), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en = 1'b0; reg_we = 1'b0; reg_addr = '0; reg_data = '0;
    mem_we = 1'b0; mem_addr = '0; mem_data = '0;
    out_ready = 1'b0; clr_ovf = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sbq.delete();
    nCompared++;
    if (count !== '0) begin nMismatch++; $display("[TB] FAIL reset_count: got %0d expected 0", count); end
    nCompared++;
    if (out_valid !== 1'b0) begin nMismatch++; $display("[TB] FAIL reset_valid: got %b expected 0", out_valid); end
    nCompared++;
    if (overflow !== 1'b0) begin nMismatch++; $display("[TB] FAIL reset_overflow: got %b expected 0", overflow); end
    nCompared++;
    if (drop_cnt !== 16'd0) begin nMismatch++; $display("[TB] FAIL reset_drop_cnt: got %0d expected 0", drop_cnt); end
  endtask

  task automatic test_reg_write();
    ent_t e;
    e.kind = 1'b0; e.addr = 32'h0000_0008; e.data = 32'h0000_002A;
    en = 1'b1; reg_we = 1'b1; reg_addr = 5'd8; reg_data = 32'h0000_002A;
    sbq.push_back(e);
    tick();
    idle();
    nCompared++;
    if (out_valid !== 1'b1) begin nMismatch++; $display("[TB] FAIL regwr_valid: got %b expected 1", out_valid); end
    nCompared++;
    if (out_kind !== sbq[0].kind) begin nMismatch++; $display("[TB] FAIL regwr_kind: got %b expected %b", out_kind, sbq[0].kind); end
    nCompared++;
    if (out_addr !== sbq[0].addr) begin nMismatch++; $display("[TB] FAIL regwr_addr: got %08h expected %08h", out_addr, sbq[0].addr); end
    nCompared++;
    if (out_data !== sbq[0].data) begin nMismatch++; $display("[TB] FAIL regwr_data: got %08h expected %08h", out_data, sbq[0].data); end
    nCompared++;
    if (count !== CNT_W'(sbq.size())) begin nMismatch++; $display("[TB] FAIL regwr_count: got %0d expected %0d", count, sbq.size()); end
    out_ready = 1'b1;
    sbq.pop_front();
    tick();
    out_ready = 1'b0;
    nCompared++;
    if (count !== '0 || out_valid !== 1'b0) begin
      nMismatch++; $display("[TB] FAIL regwr_pop: got count=%0d valid=%b expected 0/0", count, out_valid);
    end
  endtask

  task automatic test_reg_zero();
    en = 1'b1; reg_we = 1'b1; reg_addr = 5'd0; reg_data = 32'hFFFF_FFFF;
    tick();
    idle();
    nCompared++;
    if (count !== '0) begin nMismatch++; $display("[TB] FAIL regzero_count: got %0d expected 0", count); end
    nCompared++;
    if (out_valid !== 1'b0) begin nMismatch++; $display("[TB] FAIL regzero_valid: got %b expected 0", out_valid); end
  endtask

  task automatic test_dual();
    ent_t e;
    e.kind = 1'b0; e.addr = 32'h0000_0009; e.data = 32'h0000_0011;
    sbq.push_back(e);
    e.kind = 1'b1; e.addr = 32'h0000_0100; e.data = 32'hDEAD_BEEF;
    sbq.push_back(e);
    en = 1'b1; reg_we = 1'b1; reg_addr = 5'd9; reg_data = 32'h11;
    mem_we = 1'b1; mem_addr = 32'h100; mem_data = 32'hDEAD_BEEF;
    out_ready = 1'b1;
    tick();
    idle();
    out_ready = 1'b1;
    for (int k = 0; k < 6 && sbq.size() != 0; k++) begin
      nCompared++;
      if ({out_valid, out_kind, out_addr, out_data} !== {1'b1, sbq[0].kind, sbq[0].addr, sbq[0].data}) begin
        nMismatch++;
        $display("[TB] FAIL dual_head: got v=%b k=%b a=%08h d=%08h expected v=1 k=%b a=%08h d=%08h",
                 out_valid, out_kind, out_addr, out_data, sbq[0].kind, sbq[0].addr, sbq[0].data);
      end
      sbq.pop_front();
      tick();
    end
    out_ready = 1'b0;
    nCompared++;
    if (count !== '0 || sbq.size() != 0) begin
      nMismatch++; $display("[TB] FAIL dual_drain: got count=%0d left=%0d expected 0/0", count, sbq.size());
    end
  endtask

  task automatic test_overflow();
    ent_t e;
    for (int i = 1; i <= 15; i++) begin
      e.kind = 1'b0; e.addr = 32'(i); e.data = 32'h100 + 32'(i);
      en = 1'b1; reg_we = 1'b1; reg_addr = 5'(i); reg_data = e.data;
      if (DEPTH - sbq.size() >= 1) sbq.push_back(e); else expDrops++;
      tick();
    end
    idle();
    nCompared++;
    if (count !== 5'd15) begin nMismatch++; $display("[TB] FAIL ovf_fill: got %0d expected 15", count); end
    // Two events with one free slot: both dropped.
    en = 1'b1; reg_we = 1'b1; reg_addr = 5'd3; reg_data = 32'hAAAA_0003;
    mem_we = 1'b1; mem_addr = 32'h200; mem_data = 32'hBBBB_0200;
    if (DEPTH - sbq.size() >= 2) begin
      e.kind = 1'b0; e.addr = 32'h3; e.data = 32'hAAAA_0003; sbq.push_back(e);
      e.kind = 1'b1; e.addr = 32'h200; e.data = 32'hBBBB_0200; sbq.push_back(e);
    end else expDrops++;
    tick();
    idle();
    nCompared++;
    if (count !== CNT_W'(sbq.size())) begin nMismatch++; $display("[TB] FAIL ovf_dual_count: got %0d expected %0d", count, sbq.size()); end
    nCompared++;
    if (overflow !== 1'b1) begin nMismatch++; $display("[TB] FAIL ovf_flag: got %b expected 1", overflow); end
    nCompared++;
    if (drop_cnt !== 16'(expDrops)) begin nMismatch++; $display("[TB] FAIL ovf_drop1: got %0d expected %0d", drop_cnt, expDrops); end
    e.kind = 1'b1; e.addr = 32'h0000_0300; e.data = 32'h1234_5678;
    en = 1'b1; mem_we = 1'b1; mem_addr = e.addr; mem_data = e.data;
    if (DEPTH - sbq.size() >= 1) sbq.push_back(e); else expDrops++;
    tick();
    idle();
    nCompared++;
    if (count !== 5'd16) begin nMismatch++; $display("[TB] FAIL ovf_full: got %0d expected 16", count); end
    // Full with a same-cycle pop: admission sees the pre-pop count, so the event drops.
    en = 1'b1; reg_we = 1'b1; reg_addr = 5'd7; reg_data = 32'h7777_7777;
    out_ready = 1'b1;
    nCompared++;
    if ({out_valid, out_kind, out_addr, out_data} !== {1'b1, sbq[0].kind, sbq[0].addr, sbq[0].data}) begin
      nMismatch++;
      $display("[TB] FAIL ovf_pop_head: got k=%b a=%08h d=%08h expected k=%b a=%08h d=%08h",
               out_kind, out_addr, out_data, sbq[0].kind, sbq[0].addr, sbq[0].data);
    end
    if (DEPTH - sbq.size() >= 1) begin
      e.kind = 1'b0; e.addr = 32'h7; e.data = 32'h7777_7777;
      sbq.pop_front(); sbq.push_back(e);
    end else begin
      sbq.pop_front(); expDrops++;
    end
    tick();
    idle();
    nCompared++;
    if (count !== CNT_W'(sbq.size())) begin nMismatch++; $display("[TB] FAIL ovf_pop_count: got %0d expected %0d", count, sbq.size()); end
    nCompared++;
    if (drop_cnt !== 16'(expDrops)) begin nMismatch++; $display("[TB] FAIL ovf_drop2: got %0d expected %0d", drop_cnt, expDrops); end
    // Clear in the same cycle as another drop: the clear wins.
    en = 1'b1; reg_we = 1'b1; reg_addr = 5'd4; mem_we = 1'b1; clr_ovf = 1'b1;
    tick();
    idle();
    expDrops = 0;
    nCompared++;
    if (overflow !== 1'b0 || drop_cnt !== 16'd0) begin
      nMismatch++; $display("[TB] FAIL ovf_clear: got ovf=%b drop=%0d expected 0/0", overflow, drop_cnt);
    end
    nCompared++;
    if (count !== CNT_W'(sbq.size())) begin nMismatch++; $display("[TB] FAIL ovf_clear_count: got %0d expected %0d", count, sbq.size()); end
    out_ready = 1'b1;
    for (int k = 0; k < 40 && sbq.size() != 0; k++) begin
      nCompared++;
      if ({out_valid, out_kind, out_addr, out_data} !== {1'b1, sbq[0].kind, sbq[0].addr, sbq[0].data}) begin
        nMismatch++;
        $display("[TB] FAIL ovf_drain_head: got v=%b k=%b a=%08h d=%08h expected v=1 k=%b a=%08h d=%08h",
                 out_valid, out_kind, out_addr, out_data, sbq[0].kind, sbq[0].addr, sbq[0].data);
      end
      sbq.pop_front();
      tick();
    end
    out_ready = 1'b0;
    nCompared++;
    if (count !== '0 || sbq.size() != 0) begin
      nMismatch++; $display("[TB] FAIL ovf_drain: got count=%0d left=%0d expected 0/0", count, sbq.size());
    end
  endtask

  task automatic test_wrap();
    ent_t e;
    logic [4:0] ra;
    for (int i = 0; i < 40; i++) begin
      idle();
      en = 1'b1;
      out_ready = i[0];
      e.kind = 1'($urandom_range(0, 1));
      e.data = $urandom;
      if (e.kind) begin
        e.addr = $urandom;
        mem_we = 1'b1; mem_addr = e.addr; mem_data = e.data;
      end else begin
        ra = 5'($urandom_range(1, 31));
        e.addr = {27'd0, ra};
        reg_we = 1'b1; reg_addr = ra; reg_data = e.data;
      end
      if (out_ready && sbq.size() != 0) begin
        nCompared++;
        if ({out_valid, out_kind, out_addr, out_data} !== {1'b1, sbq[0].kind, sbq[0].addr, sbq[0].data}) begin
          nMismatch++;
          $display("[TB] FAIL wrap_head[%0d]: got v=%b k=%b a=%08h d=%08h expected v=1 k=%b a=%08h d=%08h",
                   i, out_valid, out_kind, out_addr, out_data, sbq[0].kind, sbq[0].addr, sbq[0].data);
        end
      end
      // Admission uses the pre-pop occupancy.
      if (DEPTH - sbq.size() >= 1) begin
        if (out_ready && sbq.size() != 0) sbq.pop_front();
        sbq.push_back(e);
      end else begin
        if (out_ready && sbq.size() != 0) sbq.pop_front();
        expDrops++;
      end
      tick();
      nCompared++;
      if (count !== CNT_W'(sbq.size()) || count > 5'd16) begin
        nMismatch++; $display("[TB] FAIL wrap_count[%0d]: got %0d expected %0d", i, count, sbq.size());
      end
    end
    idle();
    nCompared++;
    if (drop_cnt !== 16'(expDrops) || overflow !== (expDrops != 0)) begin
      nMismatch++; $display("[TB] FAIL wrap_drops: got drop=%0d ovf=%b expected %0d/%b", drop_cnt, overflow, expDrops, expDrops != 0);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 40 && sbq.size() != 0; k++) begin
      nCompared++;
      if ({out_valid, out_kind, out_addr, out_data} !== {1'b1, sbq[0].kind, sbq[0].addr, sbq[0].data}) begin
        nMismatch++;
        $display("[TB] FAIL wrap_drain_head: got v=%b k=%b a=%08h d=%08h expected v=1 k=%b a=%08h d=%08h",
                 out_valid, out_kind, out_addr, out_data, sbq[0].kind, sbq[0].addr, sbq[0].data);
      end
      sbq.pop_front();
      tick();
    end
    out_ready = 1'b0;
    nCompared++;
    if (count !== '0 || sbq.size() != 0) begin
      nMismatch++; $display("[TB] FAIL wrap_drain: got count=%0d left=%0d expected 0/0", count, sbq.size());
    end
  endtask

  task automatic test_reset_midstream();
    ent_t e;
    for (int i = 0; i < 5; i++) begin
      e.kind = 1'b1; e.addr = 32'h4000 + 32'(i); e.data = 32'hC0DE_0000 + 32'(i);
      en = 1'b1; mem_we = 1'b1; mem_addr = e.addr; mem_data = e.data;
      sbq.push_back(e);
      tick();
    end
    idle();
    nCompared++;
    if (count !== 5'd5) begin nMismatch++; $display("[TB] FAIL midrst_fill: got %0d expected 5", count); end
    rst = 1'b1; en = 1'b1; reg_we = 1'b1; reg_addr = 5'd12; out_ready = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    sbq.delete();
    expDrops = 0;
    nCompared++;
    if (count !== '0 || out_valid !== 1'b0) begin
      nMismatch++; $display("[TB] FAIL midrst_state: got count=%0d valid=%b expected 0/0", count, out_valid);
    end
    nCompared++;
    if (overflow !== 1'b0 || drop_cnt !== 16'd0) begin
      nMismatch++; $display("[TB] FAIL midrst_flags: got ovf=%b drop=%0d expected 0/0", overflow, drop_cnt);
    end
    e.kind = 1'b0; e.addr = 32'h1F; e.data = 32'h5A5A_A5A5;
    en = 1'b1; reg_we = 1'b1; reg_addr = 5'd31; reg_data = e.data;
    sbq.push_back(e);
    tick();
    idle();
    nCompared++;
    if ({out_valid, out_kind, out_addr, out_data, count} !== {1'b1, sbq[0].kind, sbq[0].addr, sbq[0].data, 5'd1}) begin
      nMismatch++;
      $display("[TB] FAIL midrst_after: got v=%b k=%b a=%08h d=%08h c=%0d expected v=1 k=%b a=%08h d=%08h c=1",
               out_valid, out_kind, out_addr, out_data, count, sbq[0].kind, sbq[0].addr, sbq[0].data);
    end
  endtask

  initial begin
    rst = 1'b0;
    idle();
    tick();
    test_reset();
    test_reg_write();
    test_reg_zero();
    test_dual();
    test_overflow();
    test_wrap();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
